// File: rtl/g2e_gearbox.sv
// Bit-level width converter between the Hamming generator and encoder stages.
// Packs WR_DATA_WIDTH-bit words into a left-aligned bit buffer and emits RD_DATA_WIDTH-bit words MSB-first.
module g2e_gearbox #(
    parameter int WR_DATA_WIDTH   = 8,
    parameter int RD_DATA_WIDTH   = 11,
    parameter int BUF_BUFFER_SIZE = 32,
    localparam int LVL_W          = $clog2(BUF_BUFFER_SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    input  logic                     wr_last,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [RD_DATA_WIDTH-1:0] rd_data,
    output logic                     rd_last,
    output logic [LVL_W-1:0]         level
);

    generate
        if (BUF_BUFFER_SIZE < WR_DATA_WIDTH + RD_DATA_WIDTH - 1) begin : g_bad_size
            $error("g2e_gearbox: BUF_BUFFER_SIZE must be >= WR_DATA_WIDTH + RD_DATA_WIDTH - 1");
        end
    endgenerate

    localparam logic [LVL_W-1:0] WR_LVL  = LVL_W'(WR_DATA_WIDTH);
    localparam logic [LVL_W-1:0] RD_LVL  = LVL_W'(RD_DATA_WIDTH);
    localparam logic [LVL_W:0]   WR_EXT  = (LVL_W + 1)'(WR_DATA_WIDTH);
    localparam logic [LVL_W:0]   CAP_EXT = (LVL_W + 1)'(BUF_BUFFER_SIZE);

    typedef enum logic {FILL, FLUSH} state_t;

    state_t                     state_q, state_d;
    logic [LVL_W-1:0]           count_q, count_d;
    logic [BUF_BUFFER_SIZE-1:0] buf_q, buf_d;

    logic                       rd_fire, wr_fire;
    logic [LVL_W-1:0]           rd_take, count_ar;
    logic [BUF_BUFFER_SIZE-1:0] shifted, inserted;

    // NOTE: every signal driven here gets a default first, so no path through the block can infer a latch.
    always_comb begin
        state_d  = state_q;
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        wr_ready = 1'b0;

        if (state_q == FLUSH) begin
            rd_valid = (count_q != '0);
            rd_last  = (count_q <= RD_LVL);
        end else begin
            rd_valid = (count_q >= RD_LVL);
        end

        rd_fire  = rd_valid && rd_ready;
        rd_take  = (count_q < RD_LVL) ? count_q : RD_LVL;
        count_ar = count_q - (rd_fire ? rd_take : '0);

        if (state_q == FILL) begin
            wr_ready = ({1'b0, count_ar} + WR_EXT <= CAP_EXT);
        end
        wr_fire = wr_valid && wr_ready;

        // Unused buffer bits are always zero, so a read of a partial word comes out zero-padded for free.
        shifted  = rd_fire ? (buf_q << RD_DATA_WIDTH) : buf_q;
        inserted = (BUF_BUFFER_SIZE'(wr_data) << (BUF_BUFFER_SIZE - WR_DATA_WIDTH)) >> count_ar;
        buf_d    = shifted | (wr_fire ? inserted : '0);
        count_d  = count_ar + (wr_fire ? WR_LVL : '0);

        case (state_q)
            FILL: begin
                if (wr_fire && wr_last && count_d != '0) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (rd_fire && rd_last) begin
                    state_d = FILL;
                    count_d = '0;
                    buf_d   = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only; the bit buffer is reset too because its zero fill is functional.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            count_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            buf_q   <= buf_d;
        end
    end

    assign rd_data = buf_q[BUF_BUFFER_SIZE-1 -: RD_DATA_WIDTH];
    assign level   = count_q;

endmodule

// File: tb/tb_g2e_gearbox.sv
// Self-checking bench for g2e_gearbox (8 -> 11 bits, 32-bit buffer).
// A bit-queue model turns accepted writes into expected output words; reads are compared against it.
module tb_g2e_gearbox;

    localparam int WR  = 8;
    localparam int RD  = 11;
    localparam int BUF = 32;
    localparam int LW  = $clog2(BUF + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [WR-1:0] wr_data = '0;
    logic          wr_last = 1'b0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [RD-1:0] rd_data;
    logic          rd_last;
    logic [LW-1:0] level;

    g2e_gearbox #(
        .WR_DATA_WIDTH  (WR),
        .RD_DATA_WIDTH  (RD),
        .BUF_BUFFER_SIZE(BUF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data (wr_data),
        .wr_last (wr_last),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data (rd_data),
        .rd_last (rd_last),
        .level   (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RD-1:0] d;
        logic          l;
    } exp_t;

    bit   bitq[$];
    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_wlast = 0;
    int   n_rlast = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void pop_word(input logic l);
        exp_t e;
        e.d = '0;
        for (int k = 0; k < RD; k++) begin
            e.d = {e.d[RD-2:0], (bitq.size() > 0) ? bitq.pop_front() : 1'b0};
        end
        e.l = l;
        expq.push_back(e);
    endfunction

    function automatic void model_write(input logic [WR-1:0] d, input logic l);
        for (int i = WR - 1; i >= 0; i--) bitq.push_back(d[i]);
        if (l) begin
            while (bitq.size() > RD) pop_word(1'b0);
            pop_word(1'b1);
        end else begin
            while (bitq.size() >= RD) pop_word(1'b0);
        end
    endfunction

    // Scoreboard: read side compared against the current outputs before this cycle's write is modelled.
    always @(negedge clk) begin
        if (rst) begin
            bitq.delete();
            expq.delete();
        end else begin
            if (rd_valid && rd_ready) begin
                if (expq.size() == 0) begin
                    check("rd_unexpected", {21'd0, rd_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("rd_data", {21'd0, rd_data}, {21'd0, e.d});
                    check("rd_last", {31'd0, rd_last}, {31'd0, e.l});
                end
                if (rd_last) n_rlast++;
            end
            if (wr_valid && wr_ready) begin
                model_write(wr_data, wr_last);
                if (wr_last) n_wlast++;
            end
        end
    end

    task automatic drive(input logic wv, input logic [WR-1:0] wd, input logic wl, input logic rr);
        wr_valid = wv;
        wr_data  = wd;
        wr_last  = wl;
        rd_ready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    int acc, acc2, words, pkt_left, cycles;
    logic          wv_cur, wl_cur, fired;
    logic [WR-1:0] wd_cur;

    initial begin
        // Reset state
        do_reset();
        check("rst_level", {26'd0, level}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_last", {31'd0, rd_last}, 32'd0);
        check("rst_rd_data", {21'd0, rd_data}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);

        // 1: two 0xFF writes give one 0x7FF read and leave 5 bits
        drive(1'b1, 8'hFF, 1'b0, 1'b1);
        drive(1'b1, 8'hFF, 1'b0, 1'b1);
        check("t1_level16", {26'd0, level}, 32'd16);
        drive(1'b0, '0, 1'b0, 1'b1);
        check("t1_level5", {26'd0, level}, 32'd5);
        check("t1_pending", expq.size(), 32'd0);

        // 2: packet flush with zero padding
        do_reset();
        drive(1'b1, 8'hA5, 1'b0, 1'b1);
        drive(1'b1, 8'h3C, 1'b0, 1'b1);
        drive(1'b1, 8'h81, 1'b1, 1'b1);
        check("t2_level13", {26'd0, level}, 32'd13);
        check("t2_flush_wr_ready", {31'd0, wr_ready}, 32'd0);
        drive(1'b0, '0, 1'b0, 1'b1);
        check("t2_last_word", {20'd0, rd_last, rd_data}, {20'd0, 1'b1, 11'h200});
        drive(1'b0, '0, 1'b0, 1'b1);
        check("t2_level0", {26'd0, level}, 32'd0);
        check("t2_fill_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("t2_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("t2_pending", expq.size(), 32'd0);

        // 3: back-pressure fills the buffer, then reads free it
        do_reset();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_data = 8'h10 + 8'(acc); wr_last = 1'b0; rd_ready = 1'b0;
            #1;
            if (wr_ready) acc++;
            @(posedge clk); #1;
        end
        check("t3_accepted", acc, 32'd4);
        check("t3_level32", {26'd0, level}, 32'd32);
        check("t3_wr_ready", {31'd0, wr_ready}, 32'd0);
        acc2 = 0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = 8'h10 + 8'(acc + acc2); wr_last = 1'b0; rd_ready = 1'b1;
            #1;
            if (wr_ready) acc2++;
            @(posedge clk); #1;
        end
        check("t3_resumed", acc2, 32'd4);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, 1'b1);

        // 4: simultaneous read and write at level 24
        do_reset();
        drive(1'b1, 8'hC3, 1'b0, 1'b0);
        drive(1'b1, 8'h96, 1'b0, 1'b0);
        drive(1'b1, 8'h0F, 1'b0, 1'b0);
        check("t4_level24", {26'd0, level}, 32'd24);
        drive(1'b1, 8'h5A, 1'b0, 1'b1);
        check("t4_level21", {26'd0, level}, 32'd21);
        drive(1'b0, '0, 1'b0, 1'b1);
        check("t4_level10", {26'd0, level}, 32'd10);

        // 5: reset in the middle of a flush
        do_reset();
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        check("t5_level13", {26'd0, level}, 32'd13);
        check("t5_mid_rd_valid", {31'd0, rd_valid}, 32'd1);
        check("t5_mid_rd_last", {31'd0, rd_last}, 32'd0);
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        check("t5_level0", {26'd0, level}, 32'd0);
        check("t5_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("t5_rd_last", {31'd0, rd_last}, 32'd0);
        check("t5_wr_ready", {31'd0, wr_ready}, 32'd1);

        // 6: random traffic with random packet lengths
        do_reset();
        n_wlast = 0; n_rlast = 0;
        words = 0; cycles = 0;
        pkt_left = $urandom_range(1, 20);
        wv_cur = 1'b0; wl_cur = 1'b0; wd_cur = '0;
        while (words < 10000 && cycles < 60000) begin
            if (!wv_cur) begin
                wv_cur = ($urandom % 4) != 0;
                wd_cur = 8'($urandom);
                wl_cur = (pkt_left == 1) || (words == 9999);
            end
            wr_valid = wv_cur; wr_data = wd_cur; wr_last = wl_cur;
            rd_ready = ($urandom % 3) != 0;
            @(negedge clk);
            fired = wr_valid && wr_ready;
            @(posedge clk); #1;
            cycles++;
            if (fired) begin
                words++;
                if (wl_cur) pkt_left = $urandom_range(1, 20);
                else pkt_left--;
                wv_cur = 1'b0;
            end
        end
        check("t6_words", words, 32'd10000);
        cycles = 0;
        while ((expq.size() != 0 || level != '0) && cycles < 200) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            cycles++;
        end
        check("t6_drained", expq.size(), 32'd0);
        check("t6_level0", {26'd0, level}, 32'd0);
        check("t6_last_count", n_rlast, n_wlast);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
